// File: rtl/spi_regs_pkg.sv
// Shared register map, bit positions and run-state encoding for the
// Avalon-MM SPI register block.
package spi_regs_pkg;

    // Word addresses
    localparam logic [7:0] ADDR_CONTROL = 8'h00;
    localparam logic [7:0] ADDR_STATUS  = 8'h01;
    localparam logic [7:0] ADDR_TXDATA  = 8'h02;
    localparam logic [7:0] ADDR_RXDATA  = 8'h03;
    localparam logic [7:0] ADDR_RESET   = 8'h04;
    localparam logic [7:0] ADDR_LEVELS  = 8'h05;

    // CONTROL bit positions
    localparam int CTRL_START       = 0;
    localparam int CTRL_CPOL        = 1;
    localparam int CTRL_CPHA        = 2;
    localparam int CTRL_IRQ_DONE_EN = 3;
    localparam int CTRL_IRQ_RX_EN   = 4;
    localparam int CTRL_CS_LSB      = 8;
    localparam int CTRL_CS_MSB      = 11;

    // STATUS bit positions
    localparam int STAT_BUSY     = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_RX_FULL  = 3;
    localparam int STAT_RX_EMPTY = 4;
    localparam int STAT_IRQ_DONE = 5;
    localparam int STAT_IRQ_RX   = 6;
    localparam int STAT_RX_OVF   = 7;
    localparam int STAT_TX_OVF   = 8;

    // Magic word that triggers the engine soft reset
    localparam logic [31:0] RESET_KEY = 32'hA5A5_A5A5;

    // Transfer run state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } run_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with synchronous clear. Head word is shown combinationally
// (zero when empty). A push into a full FIFO succeeds only if a pop happens in
// the same cycle; otherwise it is dropped and 'overflow' pulses.
module spi_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     rd_ptr_r;
    logic [AW-1:0]     wr_ptr_r;
    logic [AW:0]       count_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == FULL_CNT);
    assign level     = count_r;
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign overflow  = push & ~do_push_s;
    assign head      = empty ? '0 : mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/avalon_spi_regs.sv
// Avalon-MM register front end for an SPI engine: control/status registers,
// TX/RX FIFOs, a run FSM, interrupt generation and a timed soft reset.
module avalon_spi_regs
    import spi_regs_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int FIFO_DEPTH = 8,
    parameter  int NUM_CS     = 4,
    parameter  int RST_CYCLES = 64,
    localparam int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              hard_reset,
    input  logic              chip_select,
    input  logic [7:0]        address,
    input  logic              write,
    input  logic [31:0]       write_data,
    input  logic              read,
    output logic [31:0]       read_data,
    output logic              wait_request,
    output logic              irq,
    output logic              soft_reset,
    output logic              go_transfer,
    output logic              cpol,
    output logic              cpha,
    output logic [CS_W-1:0]   cs_sel,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              spi_busy
);

    localparam int          LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int          CNT_W    = $clog2(RST_CYCLES + 1);
    localparam logic [31:0] NUM_CS_U = 32'(NUM_CS);

    // Registers
    logic              soft_reset_r;
    logic [CNT_W-1:0]  rst_cnt_r;
    logic              read_pend_r;
    logic [31:0]       read_data_r;
    logic              cpol_r;
    logic              cpha_r;
    logic              irq_done_en_r;
    logic              irq_rx_en_r;
    logic [CS_W-1:0]   cs_sel_r;
    logic              irq_done_r;
    logic              irq_rx_r;
    logic              rx_ovf_r;
    logic              tx_ovf_r;
    logic              irq_r;
    run_state_t        state_r;
    logic              go_r;

    // Combinational signals
    logic              clr_s;
    logic              wr_s;
    logic              rd_start_s;
    logic              reset_hit_s;
    logic              start_s;
    logic              ctrl_wr_s;
    logic              status_w1c_s;
    logic              tx_push_s;
    logic              rx_pop_s;
    logic              rx_push_s;
    logic              done_s;
    logic              cs_ok_s;
    logic [DATA_W-1:0] tx_head_s;
    logic [DATA_W-1:0] rx_head_s;
    logic              tx_full_s, tx_empty_s, tx_ovf_s;
    logic              rx_full_s, rx_empty_s, rx_ovf_s;
    logic [LVL_W-1:0]  tx_level_s;
    logic [LVL_W-1:0]  rx_level_s;
    logic [31:0]       ctrl_rd_s;
    logic [31:0]       status_rd_s;
    logic [31:0]       rxdata_rd_s;
    logic [31:0]       levels_rd_s;
    logic [31:0]       rd_mux_s;

    // Bus decode; register writes are blocked while the soft reset runs
    assign wr_s         = chip_select & write & ~soft_reset_r;
    assign rd_start_s   = chip_select & read & ~read_pend_r;
    assign reset_hit_s  = wr_s & (address == ADDR_RESET) & (write_data == RESET_KEY);
    assign ctrl_wr_s    = wr_s & (address == ADDR_CONTROL);
    assign start_s      = ctrl_wr_s & write_data[CTRL_START];
    assign status_w1c_s = wr_s & (address == ADDR_STATUS);
    assign tx_push_s    = wr_s & (address == ADDR_TXDATA);
    assign rx_pop_s     = rd_start_s & (address == ADDR_RXDATA);
    assign rx_push_s    = rx_valid;
    assign cs_ok_s      = ({28'd0, write_data[CTRL_CS_MSB:CTRL_CS_LSB]} < NUM_CS_U);

    // The key write clears state on the same edge soft_reset rises
    assign clr_s  = hard_reset | soft_reset_r | reset_hit_s;
    assign done_s = (state_r == ST_DRAIN) & ~spi_busy;

    spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .clr       (clr_s),
        .push      (tx_push_s),
        .push_data (write_data[DATA_W-1:0]),
        .pop       (tx_ready),
        .head      (tx_head_s),
        .full      (tx_full_s),
        .empty     (tx_empty_s),
        .level     (tx_level_s),
        .overflow  (tx_ovf_s)
    );

    spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .clr       (clr_s),
        .push      (rx_push_s),
        .push_data (rx_data),
        .pop       (rx_pop_s),
        .head      (rx_head_s),
        .full      (rx_full_s),
        .empty     (rx_empty_s),
        .level     (rx_level_s),
        .overflow  (rx_ovf_s)
    );

    // Soft-reset pulse generator; only a hard reset can cut it short
    always_ff @(posedge clk) begin
        if (hard_reset) begin
            soft_reset_r <= 1'b0;
            rst_cnt_r    <= '0;
        end else if (reset_hit_s) begin
            soft_reset_r <= 1'b1;
            rst_cnt_r    <= CNT_W'(RST_CYCLES - 1);
        end else if (soft_reset_r) begin
            if (rst_cnt_r == '0) begin
                soft_reset_r <= 1'b0;
            end else begin
                rst_cnt_r <= rst_cnt_r - 1'b1;
            end
        end else begin
            rst_cnt_r <= rst_cnt_r;
        end
    end

    // Two-cycle read handshake: capture data and side effect on the first cycle
    always_ff @(posedge clk) begin
        if (hard_reset) begin
            read_pend_r <= 1'b0;
            read_data_r <= 32'd0;
        end else begin
            read_pend_r <= rd_start_s;
            if (rd_start_s) begin
                read_data_r <= rd_mux_s;
            end
        end
    end

    // CONTROL register fields; out-of-range slave indices are ignored
    always_ff @(posedge clk) begin
        if (clr_s) begin
            cpol_r        <= 1'b0;
            cpha_r        <= 1'b0;
            irq_done_en_r <= 1'b0;
            irq_rx_en_r   <= 1'b0;
            cs_sel_r      <= '0;
        end else if (ctrl_wr_s) begin
            cpol_r        <= write_data[CTRL_CPOL];
            cpha_r        <= write_data[CTRL_CPHA];
            irq_done_en_r <= write_data[CTRL_IRQ_DONE_EN];
            irq_rx_en_r   <= write_data[CTRL_IRQ_RX_EN];
            if (cs_ok_s) begin
                cs_sel_r <= write_data[CTRL_CS_LSB +: CS_W];
            end
        end
    end

    // Sticky STATUS flags; a new event in the clearing cycle wins over W1C
    always_ff @(posedge clk) begin
        if (clr_s) begin
            irq_done_r <= 1'b0;
            irq_rx_r   <= 1'b0;
            rx_ovf_r   <= 1'b0;
            tx_ovf_r   <= 1'b0;
        end else begin
            irq_done_r <= done_s | (irq_done_r & ~(status_w1c_s & write_data[STAT_IRQ_DONE]));
            irq_rx_r   <= (rx_push_s & ~rx_ovf_s) | (irq_rx_r & ~(status_w1c_s & write_data[STAT_IRQ_RX]));
            rx_ovf_r   <= rx_ovf_s | (rx_ovf_r & ~(status_w1c_s & write_data[STAT_RX_OVF]));
            tx_ovf_r   <= tx_ovf_s | (tx_ovf_r & ~(status_w1c_s & write_data[STAT_TX_OVF]));
        end
    end

    // Run FSM with registered go_transfer
    always_ff @(posedge clk) begin
        if (clr_s) begin
            state_r <= ST_IDLE;
            go_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s && !tx_empty_s) begin
                        state_r <= ST_RUN;
                        go_r    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (tx_empty_s) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!spi_busy) begin
                        state_r <= ST_IDLE;
                        go_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    go_r    <= 1'b0;
                end
            endcase
        end
    end

    // Registered interrupt line
    always_ff @(posedge clk) begin
        if (clr_s) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= (irq_done_r & irq_done_en_r) | (irq_rx_r & irq_rx_en_r);
        end
    end

    // Read-back images of CONTROL, STATUS, RXDATA and LEVELS
    always_comb begin
        ctrl_rd_s                            = 32'd0;
        ctrl_rd_s[CTRL_CPOL]                 = cpol_r;
        ctrl_rd_s[CTRL_CPHA]                 = cpha_r;
        ctrl_rd_s[CTRL_IRQ_DONE_EN]          = irq_done_en_r;
        ctrl_rd_s[CTRL_IRQ_RX_EN]            = irq_rx_en_r;
        ctrl_rd_s[CTRL_CS_LSB +: CS_W]       = cs_sel_r;
        status_rd_s                          = 32'd0;
        status_rd_s[STAT_BUSY]               = go_r;
        status_rd_s[STAT_TX_FULL]            = tx_full_s;
        status_rd_s[STAT_TX_EMPTY]           = tx_empty_s;
        status_rd_s[STAT_RX_FULL]            = rx_full_s;
        status_rd_s[STAT_RX_EMPTY]           = rx_empty_s;
        status_rd_s[STAT_IRQ_DONE]           = irq_done_r;
        status_rd_s[STAT_IRQ_RX]             = irq_rx_r;
        status_rd_s[STAT_RX_OVF]             = rx_ovf_r;
        status_rd_s[STAT_TX_OVF]             = tx_ovf_r;
        rxdata_rd_s                          = 32'd0;
        rxdata_rd_s[DATA_W-1:0]              = rx_head_s;
        levels_rd_s                          = 32'd0;
        levels_rd_s[LVL_W-1:0]               = tx_level_s;
        levels_rd_s[16 +: LVL_W]             = rx_level_s;
    end

    // Read data multiplexer; unmapped addresses read zero
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            ADDR_CONTROL: rd_mux_s = ctrl_rd_s;
            ADDR_STATUS:  rd_mux_s = status_rd_s;
            ADDR_RXDATA:  rd_mux_s = rxdata_rd_s;
            ADDR_LEVELS:  rd_mux_s = levels_rd_s;
            default:      rd_mux_s = 32'd0;
        endcase
    end

    assign read_data    = read_data_r;
    assign wait_request = rd_start_s;
    assign irq          = irq_r;
    assign soft_reset   = soft_reset_r;
    assign go_transfer  = go_r;
    assign cpol         = cpol_r;
    assign cpha         = cpha_r;
    assign cs_sel       = cs_sel_r;
    assign tx_data      = tx_head_s;
    assign tx_valid     = ~tx_empty_s;

endmodule

// File: tb/tb_avalon_spi_regs.sv
// Directed self-checking bench for avalon_spi_regs (default parameters).
module tb_avalon_spi_regs;

    logic        clk;
    logic        hard_reset;
    logic        chip_select;
    logic [7:0]  address;
    logic        write;
    logic [31:0] write_data;
    logic        read;
    logic [31:0] read_data;
    logic        wait_request;
    logic        irq;
    logic        soft_reset;
    logic        go_transfer;
    logic        cpol;
    logic        cpha;
    logic [1:0]  cs_sel;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        spi_busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    avalon_spi_regs dut (
        .clk          (clk),
        .hard_reset   (hard_reset),
        .chip_select  (chip_select),
        .address      (address),
        .write        (write),
        .write_data   (write_data),
        .read         (read),
        .read_data    (read_data),
        .wait_request (wait_request),
        .irq          (irq),
        .soft_reset   (soft_reset),
        .go_transfer  (go_transfer),
        .cpol         (cpol),
        .cpha         (cpha),
        .cs_sel       (cs_sel),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .spi_busy     (spi_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        chip_select = 1'b1; write = 1'b1; address = a; write_data = d;
        @(negedge clk);
        chip_select = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d,
                            output logic w1, output logic w2);
        @(negedge clk);
        chip_select = 1'b1; read = 1'b1; address = a;
        #1 w1 = wait_request;
        @(negedge clk);
        w2 = wait_request;
        d  = read_data;
        chip_select = 1'b0; read = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic w1, w2;
        hard_reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++; if ({read_data, wait_request, irq, soft_reset, go_transfer, cpol, cpha, cs_sel, tx_valid} !== 41'd0)
            $display("FAIL reset_outputs: got rd=%h wr=%b irq=%b sr=%b go=%b cpol=%b cpha=%b cs=%0d txv=%b, want all 0",
                     read_data, wait_request, irq, soft_reset, go_transfer, cpol, cpha, cs_sel, tx_valid);
        else pass_cnt++;
        hard_reset = 1'b0;
        bus_read(8'h01, d, w1, w2);
        total_cnt++; if (d !== 32'h0000_0014) $display("FAIL reset_status: got %h want 00000014", d); else pass_cnt++;
        bus_read(8'h05, d, w1, w2);
        total_cnt++; if (d !== 32'h0000_0000) $display("FAIL reset_levels: got %h want 00000000", d); else pass_cnt++;
    endtask

    task automatic test_transfer();
        logic [31:0] d;
        logic w1, w2;
        logic [31:0] exp_words [3];
        exp_words[0] = 32'h11; exp_words[1] = 32'h22; exp_words[2] = 32'h33;
        bus_write(8'h00, 32'h0000_0001);
        total_cnt++; if (go_transfer !== 1'b0) $display("FAIL start_empty_ignored: go=%b want 0", go_transfer); else pass_cnt++;
        for (int i = 0; i < 3; i++) bus_write(8'h02, exp_words[i]);
        bus_read(8'h05, d, w1, w2);
        total_cnt++; if (d !== 32'h0000_0003) $display("FAIL levels_tx3: got %h want 00000003", d); else pass_cnt++;
        spi_busy = 1'b1;
        bus_write(8'h00, 32'h0000_0001);
        total_cnt++; if (go_transfer !== 1'b1) $display("FAIL go_high: go=%b want 1", go_transfer); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (tx_data !== exp_words[i] || tx_valid !== 1'b1)
                $display("FAIL tx_order[%0d]: got %h valid=%b want %h valid=1", i, tx_data, tx_valid, exp_words[i]);
            else pass_cnt++;
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
        repeat (3) @(negedge clk);
        total_cnt++; if (go_transfer !== 1'b1) $display("FAIL drain_holds_go: go=%b want 1", go_transfer); else pass_cnt++;
        spi_busy = 1'b0;
        @(negedge clk);
        total_cnt++; if (go_transfer !== 1'b0) $display("FAIL go_low_after_drain: go=%b want 0", go_transfer); else pass_cnt++;
        bus_read(8'h01, d, w1, w2);
        total_cnt++; if (d !== 32'h0000_0034) $display("FAIL status_irq_done: got %h want 00000034", d); else pass_cnt++;
        bus_read(8'h05, d, w1, w2);
        total_cnt++; if (d !== 32'h0000_0000) $display("FAIL levels_after_run: got %h want 00000000", d); else pass_cnt++;
        bus_write(8'h01, 32'h0000_0020);
        bus_read(8'h01, d, w1, w2);
        total_cnt++; if (d !== 32'h0000_0014) $display("FAIL w1c_irq_done: got %h want 00000014", d); else pass_cnt++;
    endtask

    task automatic test_hard_abort();
        bus_write(8'h02, 32'h77);
        bus_write(8'h00, 32'h0000_0001);
        @(negedge clk);
        hard_reset = 1'b1;
        @(negedge clk);
        hard_reset = 1'b0;
        total_cnt++; if (go_transfer !== 1'b0 || tx_valid !== 1'b0)
            $display("FAIL hard_abort: go=%b txv=%b want 0 0", go_transfer, tx_valid);
        else pass_cnt++;
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        logic w1, w2;
        for (int i = 1; i <= 9; i++) bus_write(8'h02, 32'(i));
        bus_read(8'h01, d, w1, w2);
        total_cnt++; if (d !== 32'h0000_0112) $display("FAIL tx_overflow_status: got %h want 00000112", d); else pass_cnt++;
        bus_read(8'h05, d, w1, w2);
        total_cnt++; if (d !== 32'h0000_0008) $display("FAIL tx_level8: got %h want 00000008", d); else pass_cnt++;
        bus_write(8'h01, 32'h0000_0100);
        bus_read(8'h01, d, w1, w2);
        total_cnt++; if (d !== 32'h0000_0012) $display("FAIL w1c_tx_ovf: got %h want 00000012", d); else pass_cnt++;
        // push and pop together on a full FIFO
        @(negedge clk);
        chip_select = 1'b1; write = 1'b1; address = 8'h02; write_data = 32'h99; tx_ready = 1'b1;
        @(negedge clk);
        chip_select = 1'b0; write = 1'b0; tx_ready = 1'b0;
        total_cnt++; if (tx_data !== 32'h2) $display("FAIL full_push_pop_head: got %h want 00000002", tx_data); else pass_cnt++;
        bus_read(8'h01, d, w1, w2);
        total_cnt++; if (d !== 32'h0000_0012) $display("FAIL full_push_pop_status: got %h want 00000012", d); else pass_cnt++;
        @(negedge clk);
        tx_ready = 1'b1;
        repeat (8) @(negedge clk);
        tx_ready = 1'b0;
        total_cnt++; if (tx_valid !== 1'b0) $display("FAIL tx_drained: txv=%b want 0", tx_valid); else pass_cnt++;
    endtask

    task automatic test_rx_read();
        logic [31:0] d;
        logic w1, w2;
        bus_read(8'h03, d, w1, w2);
        total_cnt++; if ({w1, w2} !== 2'b10) $display("FAIL rx_empty_handshake: got %b%b want 10", w1, w2); else pass_cnt++;
        total_cnt++; if (d !== 32'h0) $display("FAIL rx_empty_data: got %h want 00000000", d); else pass_cnt++;
        bus_read(8'h05, d, w1, w2);
        total_cnt++; if (d !== 32'h0) $display("FAIL rx_empty_level: got %h want 00000000", d); else pass_cnt++;
        @(negedge clk);
        rx_data = 32'hAB; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        bus_read(8'h05, d, w1, w2);
        total_cnt++; if (d !== 32'h0001_0000) $display("FAIL rx_level1: got %h want 00010000", d); else pass_cnt++;
        bus_read(8'h03, d, w1, w2);
        total_cnt++; if (d !== 32'hAB || {w1, w2} !== 2'b10) $display("FAIL rx_read_ab: got %h hs=%b%b want 000000ab hs=10", d, w1, w2); else pass_cnt++;
        bus_read(8'h05, d, w1, w2);
        total_cnt++; if (d !== 32'h0) $display("FAIL rx_single_pop: got %h want 00000000", d); else pass_cnt++;
        total_cnt++; if (irq !== 1'b0) $display("FAIL irq_masked: irq=%b want 0", irq); else pass_cnt++;
        bus_write(8'h01, 32'h0000_0040);
    endtask

    task automatic test_irq_rx();
        logic [31:0] d;
        logic w1, w2;
        bus_write(8'h00, 32'h0000_0010);
        rx_data = 32'h5A; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        total_cnt++; if (irq !== 1'b0) $display("FAIL irq_latency: irq=%b want 0", irq); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (irq !== 1'b1) $display("FAIL irq_rx_high: irq=%b want 1", irq); else pass_cnt++;
        bus_write(8'h01, 32'h0000_0040);
        @(negedge clk);
        total_cnt++; if (irq !== 1'b0) $display("FAIL irq_rx_cleared: irq=%b want 0", irq); else pass_cnt++;
        bus_read(8'h03, d, w1, w2);
        total_cnt++; if (d !== 32'h5A) $display("FAIL rx_read_5a: got %h want 0000005a", d); else pass_cnt++;
        bus_write(8'h00, 32'h0000_0000);
    endtask

    task automatic test_rx_overflow();
        logic [31:0] d;
        logic w1, w2;
        @(negedge clk);
        rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_data = 32'h30 + 32'(i);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        bus_read(8'h01, d, w1, w2);
        total_cnt++; if (d !== 32'h0000_00CC) $display("FAIL rx_overflow_status: got %h want 000000cc", d); else pass_cnt++;
        bus_read(8'h05, d, w1, w2);
        total_cnt++; if (d !== 32'h0008_0000) $display("FAIL rx_level8: got %h want 00080000", d); else pass_cnt++;
        bus_read(8'h03, d, w1, w2);
        total_cnt++; if (d !== 32'h30) $display("FAIL rx_first_kept: got %h want 00000030", d); else pass_cnt++;
    endtask

    task automatic test_cs_sel();
        logic [31:0] d;
        logic w1, w2;
        bus_write(8'h00, 32'h0000_0204);
        total_cnt++; if (cs_sel !== 2'd2 || cpha !== 1'b1) $display("FAIL cs_sel_2: cs=%0d cpha=%b want 2 1", cs_sel, cpha); else pass_cnt++;
        bus_read(8'h00, d, w1, w2);
        total_cnt++; if (d !== 32'h0000_0204) $display("FAIL control_readback: got %h want 00000204", d); else pass_cnt++;
        bus_write(8'h00, 32'h0000_0700);
        total_cnt++; if (cs_sel !== 2'd2) $display("FAIL cs_sel_7_ignored: cs=%0d want 2", cs_sel); else pass_cnt++;
        bus_read(8'h10, d, w1, w2);
        total_cnt++; if (d !== 32'h0) $display("FAIL unmapped_read: got %h want 00000000", d); else pass_cnt++;
    endtask

    task automatic test_soft_reset();
        logic [31:0] d;
        logic w1, w2;
        int n;
        bus_write(8'h04, 32'h1234_5678);
        total_cnt++; if (soft_reset !== 1'b0) $display("FAIL wrong_key_ignored: sr=%b want 0", soft_reset); else pass_cnt++;
        bus_write(8'h02, 32'h5);
        bus_write(8'h00, 32'h0000_0103);
        total_cnt++; if (go_transfer !== 1'b1 || cpol !== 1'b1 || cs_sel !== 2'd1)
            $display("FAIL pre_soft_run: go=%b cpol=%b cs=%0d want 1 1 1", go_transfer, cpol, cs_sel);
        else pass_cnt++;
        bus_write(8'h04, 32'hA5A5_A5A5);
        total_cnt++; if (soft_reset !== 1'b1 || go_transfer !== 1'b0)
            $display("FAIL soft_reset_entry: sr=%b go=%b want 1 0", soft_reset, go_transfer);
        else pass_cnt++;
        n = 0;
        while (soft_reset === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        total_cnt++; if (n !== 64) $display("FAIL soft_reset_len: got %0d cycles want 64", n); else pass_cnt++;
        total_cnt++; if (cpol !== 1'b0 || cs_sel !== 2'd0 || tx_valid !== 1'b0)
            $display("FAIL soft_reset_outputs: cpol=%b cs=%0d txv=%b want 0 0 0", cpol, cs_sel, tx_valid);
        else pass_cnt++;
        bus_read(8'h00, d, w1, w2);
        total_cnt++; if (d !== 32'h0) $display("FAIL soft_reset_control: got %h want 00000000", d); else pass_cnt++;
        bus_read(8'h01, d, w1, w2);
        total_cnt++; if (d !== 32'h0000_0014) $display("FAIL soft_reset_status: got %h want 00000014", d); else pass_cnt++;
        bus_read(8'h05, d, w1, w2);
        total_cnt++; if (d !== 32'h0) $display("FAIL soft_reset_levels: got %h want 00000000", d); else pass_cnt++;
    endtask

    initial begin
        hard_reset  = 1'b1;
        chip_select = 1'b0;
        address     = 8'h00;
        write       = 1'b0;
        write_data  = 32'h0;
        read        = 1'b0;
        tx_ready    = 1'b0;
        rx_data     = 32'h0;
        rx_valid    = 1'b0;
        spi_busy    = 1'b0;
        test_reset();
        test_transfer();
        test_hard_abort();
        test_tx_overflow();
        test_rx_read();
        test_irq_rx();
        test_rx_overflow();
        test_cs_sel();
        test_soft_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/avalon_spi_regs.md
AVALON_SPI_REGS -- requirements
Module: avalon_spi_regs

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the SPI word width (legal range 8..32; narrower words occupy bits [DATA_W-1:0], upper bits zero on read).
REQ-002 Parameter FIFO_DEPTH, default 8, SHALL set the TX and RX FIFO depth (power of 2, 2..256).
REQ-003 Parameter NUM_CS, default 4, SHALL set the number of selectable slave channels (CS_W = max(1,clog2(NUM_CS))).
REQ-004 Parameter RST_CYCLES, default 64, SHALL set the soft-reset pulse length in clocks.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  sole clock, all logic on rising edge
- hard_reset  in  1  synchronous active-high reset
- chip_select  in  1  Avalon slave select
- address  in  8  word address
- write  in  1  Avalon write strobe
- write_data  in  32  Avalon write data
- read  in  1  Avalon read strobe
- read_data  out  32  Avalon read data
- wait_request  out  1  Avalon wait request
- irq  out  1  level interrupt
- soft_reset  out  1  reset to SPI engine, high during soft reset
- go_transfer  out  1  run level to SPI engine
- cpol  out  1  clock polarity
- cpha  out  1  clock phase
- cs_sel  out  CS_W  active slave index
- tx_data  out  DATA_W  TX FIFO head
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  engine pops TX head
- rx_data  in  DATA_W  received word
- rx_valid  in  1  push rx_data into RX FIFO
- spi_busy  in  1  engine shifting a word

Function
REQ-006 Register map: 0x00 CONTROL, 0x01 STATUS, 0x02 TXDATA, 0x03 RXDATA, 0x04 RESET, 0x05 LEVELS; other addresses read 0, writes ignored.
REQ-007 CONTROL bits: [0] START (write-1 self-clearing, reads 0), [1] cpol, [2] cpha, [3] irq_done_en, [4] irq_rx_en, [11:8] cs index (values >= NUM_CS SHALL be ignored, cs_sel unchanged).
REQ-008 STATUS bits: [0] busy (=go_transfer), [1] tx_full, [2] tx_empty, [3] rx_full, [4] rx_empty, [5] irq_done, [6] irq_rx, [7] rx_overflow, [8] tx_overflow; bits 5..8 SHALL be cleared by writing 1 (W1C) to STATUS.
REQ-009 Writes: zero wait states; action on the clock where chip_select & write.
REQ-010 Reads: wait_request high on the first cycle of chip_select & read, low on the second, with read_data valid on that second cycle; exactly one read side effect per transfer.
REQ-011 TXDATA write SHALL push write_data[DATA_W-1:0]; push when full SHALL be dropped and set tx_overflow.
REQ-012 RXDATA read SHALL pop the RX FIFO and return the head; read when empty SHALL return 0 with no pop.
REQ-013 rx_valid when RX FIFO full SHALL drop the word and set rx_overflow.
REQ-014 Simultaneous push and pop on a full FIFO SHALL both occur with level unchanged; on an empty FIFO the pop is ignored and the push occurs.
REQ-015 LEVELS read SHALL return {rx_level[15:0], tx_level[15:0]}.
REQ-016 Run FSM, states IDLE -> RUN -> DRAIN -> IDLE: START with TX non-empty moves IDLE->RUN (go_transfer=1); RUN->DRAIN when TX empty; DRAIN->IDLE when spi_busy=0, setting irq_done in that cycle; START in RUN/DRAIN, or with TX empty in IDLE, SHALL be ignored.
REQ-017 irq_rx SHALL set on each RX push; irq = (irq_done & irq_done_en) | (irq_rx & irq_rx_en), registered, one-cycle latency.
REQ-018 Writing 0xA5A5A5A5 to RESET SHALL hold soft_reset high for RST_CYCLES clocks starting the next cycle, clearing every register, FIFO and FSM except the soft-reset counter itself; other values ignored.

Reset
REQ-019 On hard_reset: read_data=0, wait_request=0, irq=0, soft_reset=0, go_transfer=0, cpol=0, cpha=0, cs_sel=0, tx_valid=0, FIFOs empty, all STATUS flags 0, FSM IDLE.
REQ-020 hard_reset mid-transfer or mid-soft-reset SHALL abort immediately to the REQ-019 state.

Structure
REQ-021 Register addresses, CONTROL/STATUS bit positions and the 0xA5A5A5A5 reset word SHALL live in shared package spi_regs_pkg.
REQ-022 TX and RX FIFOs SHALL be two instances of one sub-module spi_sync_fifo (DATA_W, FIFO_DEPTH, push/pop/full/empty/level).

Verification
REQ-023 Write 0x11,0x22,0x33 to TXDATA, START -> go_transfer high, tx_data 0x11/0x22/0x33 in order, irq_done=1 after spi_busy falls, LEVELS tx=0.
REQ-024 FIFO_DEPTH=8: 9 TXDATA writes -> tx_full=1, tx_level=8, tx_overflow=1; W1C STATUS bit 8 -> 0.
REQ-025 Read RXDATA empty -> wait_request 1 then 0, read_data=0, rx_level stays 0; push 0xAB then read -> 0xAB.
REQ-026 irq_rx_en=1, rx_valid pulse -> irq high one cycle after irq_rx sets; W1C bit 6 -> irq low next cycle.
REQ-027 Write 0xA5A5A5A5 to RESET during RUN -> soft_reset high exactly 64 cycles, go_transfer=0, FIFOs empty, CONTROL=0.
REQ-028 CONTROL write cs index 7 with NUM_CS=4 -> cs_sel unchanged; cs index 2 -> cs_sel=2.
